// File: rtl/tsfm_multi_ctrl.sv
// TurboSound FM bus controller for 1..4 YM2203-class chips.
//
// Decodes #FFFD / #BFFD on the Z80 expansion bus, keeps the selected chip,
// status-read mode and per-chip FM enables, drives the chip selects and A0,
// and stalls the CPU (n_wait) while the selected chip is still recovering
// from a previous register-address or data write.
//
// Ports:
//   clkcpu    CPU clock, rising edge
//   rst_n     asynchronous active-low reset
//   ena       block enable; 0 disables decode and all config changes
//   a, d      CPU address / write data
//   n_rd, n_wr, n_iorq, n_m1  Z80 strobes
//   n_cs      per-chip select, active low
//   aa0       chip A0 (0 = address/status, 1 = data)
//   fm_ena    per-chip FM-part enable
//   sel       selected chip index
//   stat_mode 1 = #FFFD read returns status
//   n_wait    CPU wait request, active low
//   iorqge    decoded port addressed (masks internal ULA ports)
module tsfm_multi_ctrl #(
  parameter int NCHIPS    = 2,
  parameter int ADDR_BUSY = 4,
  parameter int DATA_BUSY = 24,
  parameter int CNTW      = 6
) (
  input  logic              clkcpu,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [15:0]       a,
  input  logic [7:0]        d,
  input  logic              n_rd,
  input  logic              n_wr,
  input  logic              n_iorq,
  input  logic              n_m1,
  output logic [NCHIPS-1:0] n_cs,
  output logic              aa0,
  output logic [NCHIPS-1:0] fm_ena,
  output logic [1:0]        sel,
  output logic              stat_mode,
  output logic              n_wait,
  output logic              iorqge
);

  logic            p_fffd, p_bffd, acc;
  logic            cmd_pfx, cmd_wr, cmd_ok, chip_acc;
  logic [1:0]      cmd_idx;
  logic            busy_sel, aa0_now, load_now;
  logic [CNTW-1:0] load_val;
  logic [CNTW-1:0] cnt [NCHIPS];
  logic            acc_q, last_wr_q, last_bffd_q, last_cmd_q, aa0_q;
  logic            unused_bits;

  // a[12:8] is not part of the port decode; d[3] only matters for >2 chips
  assign unused_bits = ^{a[12:8], d[3]};

  assign p_fffd = ena & (a[15:13] == 3'b111) & (a[7:0] == 8'hFD);
  assign p_bffd = ena & (a[15:13] == 3'b101) & (a[7:0] == 8'hFD);
  assign acc    = ~n_iorq & n_m1 & (p_fffd | p_bffd) & (~n_rd | ~n_wr);
  assign iorqge = p_fffd | p_bffd;

  always_comb begin
    cmd_pfx = 1'b0;
    cmd_idx = 2'b00;
    if (NCHIPS <= 2) begin
      cmd_pfx = (d[7:3] == 5'b11111);
      cmd_idx = {1'b0, ~d[0]};
    end else begin
      cmd_pfx = (d[7:4] == 4'hF);
      cmd_idx = ~{d[3], d[0]};
    end
  end

  // A prefixed write is a command even when the index is out of range;
  // it is then swallowed without touching the chips.
  assign cmd_wr   = acc & p_fffd & ~n_wr & cmd_pfx;
  assign cmd_ok   = cmd_wr & (int'(cmd_idx) < NCHIPS);
  assign chip_acc = acc & ~cmd_wr;

  always_comb begin
    busy_sel = 1'b0;
    for (int i = 0; i < NCHIPS; i++)
      if ((sel == 2'(i)) && (cnt[i] != '0)) busy_sel = 1'b1;
  end

  always_comb begin
    n_cs = '1;
    for (int i = 0; i < NCHIPS; i++)
      n_cs[i] = ~(chip_acc & ~busy_sel & (sel == 2'(i)));
  end

  assign n_wait  = ~(chip_acc & busy_sel);
  assign aa0_now = (p_bffd & ~n_wr) | (p_fffd & ~n_rd & ~stat_mode);
  // Outside I/O cycles A0 keeps whatever the last I/O cycle drove
  assign aa0     = n_iorq ? aa0_q : aa0_now;

  // The ended access is described by what was latched while it was active,
  // since the bus has already moved on at the edge where it ends.
  assign load_now = acc_q & ~acc & last_wr_q & ~last_cmd_q;
  assign load_val = last_bffd_q ? CNTW'(DATA_BUSY) : CNTW'(ADDR_BUSY);

  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      sel       <= 2'b00;
      stat_mode <= 1'b0;
      fm_ena    <= '0;
    end else if (cmd_ok) begin
      sel       <= cmd_idx;
      stat_mode <= ~d[1];
      for (int i = 0; i < NCHIPS; i++)
        if (cmd_idx == 2'(i)) fm_ena[i] <= ~d[2];
    end
  end

  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= 1'b0;
      last_wr_q   <= 1'b0;
      last_bffd_q <= 1'b0;
      last_cmd_q  <= 1'b0;
      aa0_q       <= 1'b0;
    end else begin
      acc_q <= acc;
      aa0_q <= aa0;
      if (acc) begin
        last_wr_q   <= ~n_wr;
        last_bffd_q <= p_bffd;
        last_cmd_q  <= cmd_wr;
      end
    end
  end

  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCHIPS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCHIPS; i++) begin
        if (load_now && (sel == 2'(i)))
          cnt[i] <= load_val;
        else if (cnt[i] != '0)
          cnt[i] <= cnt[i] - CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_tsfm_multi_ctrl.sv
// Bench for tsfm_multi_ctrl: main instance with 2 chips checked every cycle
// against a ready-time model, plus 4- and 3-chip instances for command decode.
module tb_tsfm_multi_ctrl;

  logic        clkcpu = 1'b0;
  logic        rst_n  = 1'b0;
  logic        ena    = 1'b1;
  logic [15:0] a      = 16'h0000;
  logic [7:0]  d      = 8'h00;
  logic        n_rd = 1'b1, n_wr = 1'b1, n_iorq = 1'b1, n_m1 = 1'b1;

  logic [1:0] n_cs, fm_ena, sel;
  logic       aa0, stat_mode, n_wait, iorqge;

  logic [3:0] n_cs4, fm_ena4;
  logic [1:0] sel4;
  logic       aa04, stat_mode4, n_wait4, iorqge4;
  logic [2:0] n_cs3, fm_ena3;
  logic [1:0] sel3;
  logic       aa03, stat_mode3, n_wait3, iorqge3;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clkcpu = ~clkcpu;

  tsfm_multi_ctrl #(.NCHIPS(2)) dut (
    .clkcpu(clkcpu), .rst_n(rst_n), .ena(ena), .a(a), .d(d),
    .n_rd(n_rd), .n_wr(n_wr), .n_iorq(n_iorq), .n_m1(n_m1),
    .n_cs(n_cs), .aa0(aa0), .fm_ena(fm_ena), .sel(sel),
    .stat_mode(stat_mode), .n_wait(n_wait), .iorqge(iorqge));

  tsfm_multi_ctrl #(.NCHIPS(4)) dut4 (
    .clkcpu(clkcpu), .rst_n(rst_n), .ena(ena), .a(a), .d(d),
    .n_rd(n_rd), .n_wr(n_wr), .n_iorq(n_iorq), .n_m1(n_m1),
    .n_cs(n_cs4), .aa0(aa04), .fm_ena(fm_ena4), .sel(sel4),
    .stat_mode(stat_mode4), .n_wait(n_wait4), .iorqge(iorqge4));

  tsfm_multi_ctrl #(.NCHIPS(3)) dut3 (
    .clkcpu(clkcpu), .rst_n(rst_n), .ena(ena), .a(a), .d(d),
    .n_rd(n_rd), .n_wr(n_wr), .n_iorq(n_iorq), .n_m1(n_m1),
    .n_cs(n_cs3), .aa0(aa03), .fm_ena(fm_ena3), .sel(sel3),
    .stat_mode(stat_mode3), .n_wait(n_wait3), .iorqge(iorqge3));

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (2 chips) ----------------
  // Each chip is free once the edge count reaches its ready time.
  int ecount = 0;
  int ready [2] = '{0, 0};
  int m_sel = 0;
  bit m_stat = 0;
  bit [1:0] m_fm = 2'b00;
  bit m_prev_acc = 0, m_last_wr = 0, m_last_bffd = 0, m_last_cmd = 0, m_aa0_hold = 0;

  function automatic bit f_fffd();
    return ena && a[15:13] == 3'b111 && a[7:0] == 8'hFD;
  endfunction
  function automatic bit f_bffd();
    return ena && a[15:13] == 3'b101 && a[7:0] == 8'hFD;
  endfunction
  function automatic bit f_acc();
    return !n_iorq && n_m1 && (f_fffd() || f_bffd()) && (!n_rd || !n_wr);
  endfunction
  function automatic bit f_cmd();
    return f_acc() && f_fffd() && !n_wr && d[7:3] == 5'b11111;
  endfunction
  function automatic bit f_aa0_now();
    return (f_bffd() && !n_wr) || (f_fffd() && !n_rd && !m_stat);
  endfunction

  initial forever begin : model
    bit acc_now, cmd_now, aa_now;
    @(posedge clkcpu or negedge rst_n);
    if (!rst_n) begin
      ready[0] = 0; ready[1] = 0;
      m_sel = 0; m_stat = 0; m_fm = 2'b00;
      m_prev_acc = 0; m_last_wr = 0; m_last_bffd = 0; m_last_cmd = 0; m_aa0_hold = 0;
    end else begin
      ecount++;
      acc_now = f_acc();
      cmd_now = f_cmd();
      aa_now  = f_aa0_now();
      if (m_prev_acc && !acc_now && m_last_wr && !m_last_cmd)
        ready[m_sel] = ecount + (m_last_bffd ? 24 : 4);
      if (!n_iorq) m_aa0_hold = aa_now;
      if (acc_now) begin
        m_last_wr = !n_wr; m_last_bffd = f_bffd(); m_last_cmd = cmd_now;
      end
      if (cmd_now) begin
        m_sel = d[0] ? 0 : 1;
        m_stat = !d[1];
        m_fm[m_sel] = !d[2];
      end
      m_prev_acc = acc_now;
    end
  end

  initial forever begin : compare
    bit chip, busy, ex_wait, ex_aa0;
    logic [1:0] ex_cs;
    @(negedge clkcpu);
    if (chk_en) begin
      chip  = f_acc() && !f_cmd();
      busy  = ecount < ready[m_sel];
      ex_cs = 2'b11;
      if (chip && !busy) ex_cs[m_sel] = 1'b0;
      ex_wait = !(chip && busy);
      ex_aa0  = n_iorq ? m_aa0_hold : f_aa0_now();
      chk("m_n_cs", 8'(n_cs), 8'(ex_cs));
      chk("m_n_wait", 8'(n_wait), 8'(ex_wait));
      chk("m_aa0", 8'(aa0), 8'(ex_aa0));
      chk("m_iorqge", 8'(iorqge), 8'(f_fffd() || f_bffd()));
      chk("m_sel", 8'(sel), 8'(m_sel));
      chk("m_stat", 8'(stat_mode), 8'(m_stat));
      chk("m_fm", 8'(fm_ena), 8'(m_fm));
    end
  end

  // ---------------- stimulus ----------------
  task automatic bus_idle();
    a = 16'h0000; d = 8'h00; n_iorq = 1'b1; n_rd = 1'b1; n_wr = 1'b1; n_m1 = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clkcpu);
    #2;
  endtask

  // One I/O cycle lasting len non-wait edges, stretched while n_wait is low.
  task automatic io_acc(input logic [15:0] addr, input logic [7:0] data, input bit rd,
                        input int len, output int waits, output logic [1:0] cs_first,
                        output logic [1:0] cs_low, output logic aa0_first);
    int n = 0, guard = 0;
    bit first = 1, w;
    a = addr; d = data; n_iorq = 1'b0;
    if (rd) n_rd = 1'b0; else n_wr = 1'b0;
    waits = 0; cs_low = 2'b00; cs_first = 2'b11; aa0_first = 1'b0;
    while (n < len && guard < 200) begin
      @(negedge clkcpu);
      w = n_wait;
      if (first) begin cs_first = n_cs; aa0_first = aa0; first = 0; end
      cs_low |= ~n_cs;
      if (!w) waits++;
      @(posedge clkcpu);
      if (w) n++;
      guard++;
    end
    chk("io_no_timeout", 8'(guard < 200), 8'd1);
    #2 bus_idle();
  endtask

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : stim
    int w;
    logic [1:0] csf, csl;
    logic a0f;
    bus_idle();
    #1 chk_en = 1;
    #1;
    chk("rst_n_cs", 8'(n_cs), 8'h03);
    chk("rst_fm", 8'(fm_ena), 8'h00);
    chk("rst_sel", 8'(sel), 8'h00);
    chk("rst_stat", 8'(stat_mode), 8'h00);
    chk("rst_wait", 8'(n_wait), 8'h01);
    chk("rst_aa0", 8'(aa0), 8'h00);
    @(posedge clkcpu); #2 rst_n = 1'b1;
    idle(2);

    // disabled block: no decode
    ena = 1'b0; a = 16'hFFFD; #1 chk("iorqge_dis", 8'(iorqge), 8'h00);
    ena = 1'b1; #1 chk("iorqge_en", 8'(iorqge), 8'h01);
    ena = 1'b0;
    io_acc(16'hFFFD, 8'h28, 0, 3, w, csf, csl, a0f);
    chk("dis_no_cs", 8'(csl), 8'h00);
    ena = 1'b1;
    idle(1);

    // select chip 1
    io_acc(16'hFFFD, 8'hFE, 0, 3, w, csf, csl, a0f);
    chk("cmd_fe_no_cs", 8'(csl), 8'h00);
    chk("cmd_fe_no_wait", 8'(w), 8'd0);
    chk("cmd_fe_sel", 8'(sel), 8'd1);
    chk("cmd_fe_stat", 8'(stat_mode), 8'd0);
    chk("cmd_fe_fm", 8'(fm_ena), 8'h00);
    idle(1);

    // register-address write on chip 1, then its 4-edge recovery
    io_acc(16'hFFFD, 8'h28, 0, 3, w, csf, csl, a0f);
    chk("addr_cs", 8'(csl), 8'h02);
    chk("addr_aa0", 8'(a0f), 8'h00);
    chk("addr_wait", 8'(w), 8'd0);
    idle(1);
    io_acc(16'hFFFD, 8'h28, 0, 3, w, csf, csl, a0f);
    chk("addr_busy4", 8'(w), 8'd4);
    idle(6);

    // data write then an address write 11 edges after it ended
    io_acc(16'hBFFD, 8'h55, 0, 3, w, csf, csl, a0f);
    chk("data_cs", 8'(csl), 8'h02);
    chk("data_aa0", 8'(a0f), 8'h01);
    chk("data_wait", 8'(w), 8'd0);
    idle(11);
    io_acc(16'hFFFD, 8'h28, 0, 3, w, csf, csl, a0f);
    chk("stall_waits", 8'(w), 8'd14);
    chk("stall_cs_high", 8'(csf), 8'h03);
    chk("stall_cs_after", 8'(csl), 8'h02);
    idle(1);

    // busy chip 0, then read status from chip 1 with no stall
    io_acc(16'hFFFD, 8'hFB, 0, 3, w, csf, csl, a0f);
    chk("cmd_fb_sel", 8'(sel), 8'd0);
    chk("cmd_fb_fm", 8'(fm_ena), 8'h01);
    idle(1);
    io_acc(16'hBFFD, 8'hAA, 0, 3, w, csf, csl, a0f);
    idle(1);
    io_acc(16'hFFFD, 8'hFC, 0, 3, w, csf, csl, a0f);
    chk("cmd_fc_no_wait", 8'(w), 8'd0);
    chk("cmd_fc_no_cs", 8'(csl), 8'h00);
    chk("cmd_fc_sel", 8'(sel), 8'd1);
    chk("cmd_fc_stat", 8'(stat_mode), 8'd1);
    idle(1);
    io_acc(16'hFFFD, 8'h00, 1, 3, w, csf, csl, a0f);
    chk("stat_rd_wait", 8'(w), 8'd0);
    chk("stat_rd_aa0", 8'(a0f), 8'h00);
    chk("stat_rd_cs", 8'(csf), 8'h01);
    idle(1);

    // reset during a stall
    io_acc(16'hBFFD, 8'h11, 0, 3, w, csf, csl, a0f);
    idle(1);
    a = 16'hFFFD; d = 8'h28; n_iorq = 1'b0; n_wr = 1'b0;
    @(negedge clkcpu);
    chk("pre_rst_wait", 8'(n_wait), 8'h00);
    @(posedge clkcpu); #4 rst_n = 1'b0;
    #1;
    chk("arst_wait", 8'(n_wait), 8'h01);
    chk("arst_sel", 8'(sel), 8'h00);
    chk("arst_cs", 8'(n_cs), 8'h02);
    chk("arst_fm", 8'(fm_ena), 8'h00);
    @(posedge clkcpu); #2 bus_idle();
    @(posedge clkcpu); #2 rst_n = 1'b1;
    idle(1);
    io_acc(16'hFFFD, 8'h28, 0, 3, w, csf, csl, a0f);
    chk("post_rst_wait", 8'(w), 8'd0);
    chk("post_rst_cs", 8'(csl), 8'h01);
    idle(1);

    // command decode with 4 and 3 chips
    io_acc(16'hFFFD, 8'hF4, 0, 3, w, csf, csl, a0f);
    chk("c4_f4_sel", 8'(sel4), 8'd3);
    chk("c4_f4_stat", 8'(stat_mode4), 8'd1);
    chk("c4_f4_fm", 8'(fm_ena4), 8'h00);
    chk("c3_f4_sel", 8'(sel3), 8'd0);
    chk("c3_f4_stat", 8'(stat_mode3), 8'd0);
    chk("c3_f4_fm", 8'(fm_ena3), 8'h00);
    idle(1);
    io_acc(16'hFFFD, 8'hF9, 0, 3, w, csf, csl, a0f);
    chk("c4_f9_sel", 8'(sel4), 8'd0);
    chk("c4_f9_fm", 8'(fm_ena4), 8'h01);
    chk("c3_f9_stat", 8'(stat_mode3), 8'd1);
    chk("c3_f9_fm", 8'(fm_ena3), 8'h01);
    chk("c2_f9_fm", 8'(fm_ena), 8'h01);
    chk("c2_f9_stat", 8'(stat_mode), 8'd1);
    idle(1);

    // data read from #FFFD with status mode off, then A0 hold
    io_acc(16'hFFFD, 8'hFB, 0, 3, w, csf, csl, a0f);
    idle(1);
    io_acc(16'hFFFD, 8'h00, 1, 3, w, csf, csl, a0f);
    chk("data_rd_aa0", 8'(a0f), 8'h01);
    idle(2);
    chk("aa0_hold", 8'(aa0), 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
